// File: rtl/nn_regs_pkg.sv
// nn_regs_pkg: register map offsets, CTRL/STATUS bit positions and FSM states
// for the perceptron coefficient register bank.
package nn_regs_pkg;

  localparam int CTRL_START = 0;
  localparam int CTRL_CLR   = 1;

  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_ERR  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int unsigned off_offset(int unsigned n);
    return 4 * n;
  endfunction

  function automatic int unsigned off_entrada(int unsigned n);
    return 4 * n + 4;
  endfunction

  function automatic int unsigned off_ctrl(int unsigned n);
    return 4 * n + 8;
  endfunction

  function automatic int unsigned off_status(int unsigned n);
    return 4 * n + 12;
  endfunction

  function automatic int unsigned off_result(int unsigned n);
    return 4 * n + 16;
  endfunction

endpackage

// File: rtl/nn_addr_decode.sv
// nn_addr_decode: full-width byte address to one-hot register select.
// sel[N_COEF+5] flags a miss (unmapped or misaligned address).
module nn_addr_decode
  import nn_regs_pkg::*;
#(
  parameter int              N_COEF = 20,
  parameter int              ADDR_W = 12,
  parameter logic [ADDR_W-1:0] BASE = 12'h800
) (
  input  logic [ADDR_W-1:0]  addr,
  output logic [N_COEF+5:0]  sel,
  output logic               hit
);

  function automatic logic [ADDR_W-1:0] at(int unsigned off);
    return BASE + ADDR_W'(off);
  endfunction

  genvar i;
  for (i = 0; i < N_COEF; i++) begin : g_coef
    assign sel[i] = (addr == at(4 * i));
  end

  assign sel[N_COEF]   = (addr == at(off_offset(N_COEF)));
  assign sel[N_COEF+1] = (addr == at(off_entrada(N_COEF)));
  assign sel[N_COEF+2] = (addr == at(off_ctrl(N_COEF)));
  assign sel[N_COEF+3] = (addr == at(off_status(N_COEF)));
  assign sel[N_COEF+4] = (addr == at(off_result(N_COEF)));

  assign hit           = |sel[N_COEF+4:0];
  assign sel[N_COEF+5] = ~hit;

endmodule

// File: rtl/nn_coeff_regfile.sv
// nn_coeff_regfile: bus-mapped coefficient/control bank for the perceptron.
// Define NN_REGFILE_SHADOW_EN to drive datapath inputs from a shadow bank.
module nn_coeff_regfile
  import nn_regs_pkg::*;
#(
  parameter int                N_COEF    = 20,
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 12'h800
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [ADDR_W-1:0]        Address,
  input  logic                     Write,
  input  logic                     Read,
  input  logic [31:0]              WriteData,
  output logic [31:0]              ReadData,
  output logic                     ReadValid,
  output logic [N_COEF*DATA_W-1:0] Coef,
  output logic [DATA_W-1:0]        Offset,
  output logic [DATA_W-1:0]        Entrada,
  output logic                     Start,
  input  logic                     Done,
  input  logic [DATA_W-1:0]        Result
);

  localparam int S_OFF  = N_COEF;
  localparam int S_ENT  = N_COEF + 1;
  localparam int S_CTRL = N_COEF + 2;
  localparam int S_STAT = N_COEF + 3;
  localparam int S_RES  = N_COEF + 4;
  localparam int S_MISS = N_COEF + 5;

`ifdef NN_REGFILE_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic [N_COEF+5:0] sel;
  logic              hit;

  nn_addr_decode #(
    .N_COEF (N_COEF),
    .ADDR_W (ADDR_W),
    .BASE   (BASE_ADDR)
  ) u_dec (
    .addr (Address),
    .sel  (sel),
    .hit  (hit)
  );

  state_t            state_q, state_d;
  logic              busy;
  logic [DATA_W-1:0] coef_q [N_COEF];
  logic [DATA_W-1:0] off_q, ent_q, res_q;
  logic              done_q, err_q;
  logic [DATA_W-1:0] wdata;
  logic [31:0]       rdata;

  logic wr_ctrl, start_req, clr_req, done_ev;
  logic start_ok, data_wr, data_we, data_drop;
  logic unused_bits;

  assign busy      = (state_q == RUN);
  assign wdata     = WriteData[DATA_W-1:0];
  assign wr_ctrl   = Write & sel[S_CTRL];
  assign start_req = wr_ctrl & WriteData[CTRL_START];
  assign clr_req   = wr_ctrl & WriteData[CTRL_CLR];
  assign done_ev   = Done & busy;
  assign data_wr   = Write & (|sel[S_ENT:0]);
  assign data_we   = data_wr & (SHADOW | ~busy);
  assign data_drop = data_wr & busy & ~SHADOW;

  assign unused_bits = &{1'b0, WriteData, sel[S_MISS]};

  // Next state; a start is only accepted from IDLE
  always_comb begin
    state_d  = state_q;
    start_ok = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_req) begin
          start_ok = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (Done) state_d = IDLE;
      end
    endcase
  end

  // State register and registered one-cycle Start pulse
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      Start   <= 1'b0;
    end else begin
      state_q <= state_d;
      Start   <= start_ok;
    end
  end

  // Front register bank written from the bus
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < N_COEF; i++) coef_q[i] <= '0;
      off_q <= '0;
      ent_q <= '0;
    end else if (data_we) begin
      for (int i = 0; i < N_COEF; i++)
        if (sel[i]) coef_q[i] <= wdata;
      if (sel[S_OFF]) off_q <= wdata;
      if (sel[S_ENT]) ent_q <= wdata;
    end
  end

  // Result capture and sticky flags; new events win over a clear
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      res_q  <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (done_ev) res_q <= Result;
      if (clr_req) begin
        done_q <= 1'b0;
        err_q  <= 1'b0;
      end
      if (done_ev) done_q <= 1'b1;
      if ((start_req & busy) | data_drop) err_q <= 1'b1;
    end
  end

  // Readback mux sees pre-write values
  always_comb begin
    rdata = '0;
    if (hit) begin
      for (int i = 0; i < N_COEF; i++)
        if (sel[i]) rdata = 32'(coef_q[i]);
      if (sel[S_OFF]) rdata = 32'(off_q);
      if (sel[S_ENT]) rdata = 32'(ent_q);
      if (sel[S_STAT]) begin
        rdata[ST_BUSY] = busy;
        rdata[ST_DONE] = done_q;
        rdata[ST_ERR]  = err_q;
      end
      if (sel[S_RES]) rdata = 32'(res_q);
    end
  end

  // Read response one cycle after the strobe
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ReadData  <= '0;
      ReadValid <= 1'b0;
    end else begin
      ReadValid <= Read;
      ReadData  <= Read ? rdata : '0;
    end
  end

`ifdef NN_REGFILE_SHADOW_EN
  logic [DATA_W-1:0] sh_coef [N_COEF];
  logic [DATA_W-1:0] sh_off, sh_ent;

  // Shadow bank snapshots the front bank when a run starts
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < N_COEF; i++) sh_coef[i] <= '0;
      sh_off <= '0;
      sh_ent <= '0;
    end else if (start_ok) begin
      for (int i = 0; i < N_COEF; i++) sh_coef[i] <= coef_q[i];
      sh_off <= off_q;
      sh_ent <= ent_q;
    end
  end

  for (genvar i = 0; i < N_COEF; i++) begin : g_out
    assign Coef[i*DATA_W +: DATA_W] = sh_coef[i];
  end
  assign Offset  = sh_off;
  assign Entrada = sh_ent;
`else
  for (genvar i = 0; i < N_COEF; i++) begin : g_out
    assign Coef[i*DATA_W +: DATA_W] = coef_q[i];
  end
  assign Offset  = off_q;
  assign Entrada = ent_q;
`endif

endmodule

// File: tb/tb_nn_coeff_regfile.sv
// tb_nn_coeff_regfile: scoreboard bench with a map-level reference model.
// Honours NN_REGFILE_SHADOW_EN the same way as the design.
module tb_nn_coeff_regfile;

  localparam int          N    = 20;
  localparam int          W    = 16;
  localparam int          OW   = N * W + 2 * W;
  localparam logic [11:0] BASE = 12'h800;
  localparam logic [11:0] A_CTRL = 12'h858;
  localparam logic [11:0] A_STAT = 12'h85C;
  localparam logic [11:0] A_RES  = 12'h860;

`ifdef NN_REGFILE_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic          Clk, Reset;
  logic [11:0]   Address;
  logic          Write, Read;
  logic [31:0]   WriteData;
  logic [31:0]   ReadData;
  logic          ReadValid;
  logic [N*W-1:0] Coef;
  logic [W-1:0]  Offset, Entrada;
  logic          Start, Done;
  logic [W-1:0]  Result;

  nn_coeff_regfile dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Address   (Address),
    .Write     (Write),
    .Read      (Read),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .ReadValid (ReadValid),
    .Coef      (Coef),
    .Offset    (Offset),
    .Entrada   (Entrada),
    .Start     (Start),
    .Done      (Done),
    .Result    (Result)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic [W-1:0] m_coef [N];
  logic [W-1:0] sh_coef [N];
  logic [W-1:0] m_off, m_ent, m_res, sh_off, sh_ent;
  bit           m_busy, m_done, m_err;
  logic [31:0]  exp_q [$];
  logic         exp_start, exp_start_nxt;
  logic [OW-1:0] exp_out;
  int           checks = 0;
  int           errors = 0;

  function automatic logic [31:0] m_read(input logic [11:0] a);
    int k;
    if (a[1:0] != 2'b00 || a < BASE) return 32'h0;
    k = int'(a - BASE) / 4;
    if (k < N) return {16'h0, m_coef[k]};
    case (k - N)
      0: return {16'h0, m_off};
      1: return {16'h0, m_ent};
      3: return {29'h0, m_err, m_done, m_busy};
      4: return {16'h0, m_res};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [OW-1:0] m_outs();
    logic [OW-1:0] o;
    o = '0;
    for (int i = 0; i < N; i++)
      o[i*W +: W] = SHADOW ? sh_coef[i] : m_coef[i];
    o[N*W +: W]     = SHADOW ? sh_off : m_off;
    o[N*W + W +: W] = SHADOW ? sh_ent : m_ent;
    return o;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_coef[i]  = '0;
      sh_coef[i] = '0;
    end
    m_off = '0; m_ent = '0; m_res = '0;
    sh_off = '0; sh_ent = '0;
    m_busy = 0; m_done = 0; m_err = 0;
    exp_q.delete();
    exp_start = 1'b0;
    exp_start_nxt = 1'b0;
    exp_out = '0;
  endtask

  task automatic model_step(input logic w, input logic r,
                            input logic [11:0] a, input logic [31:0] d,
                            input logic dn, input logic [15:0] res);
    bit dev, acc;
    int k;
    acc = 0;
    if (r) exp_q.push_back(m_read(a));
    dev = dn && m_busy;
    if (w && a[1:0] == 2'b00 && a >= BASE) begin
      k = int'(a - BASE) / 4;
      if (k <= N + 1) begin
        if (!m_busy || SHADOW) begin
          if (k < N) m_coef[k] = d[15:0];
          else if (k == N) m_off = d[15:0];
          else m_ent = d[15:0];
        end else begin
          m_err = 1;
        end
      end else if (k == N + 2) begin
        if (d[1]) begin
          m_done = 0;
          m_err  = 0;
        end
        if (d[0]) begin
          if (m_busy) m_err = 1;
          else acc = 1;
        end
      end
    end
    if (dev) begin
      m_busy = 0;
      m_done = 1;
      m_res  = res;
    end
    if (acc) begin
      m_busy = 1;
      for (int i = 0; i < N; i++) sh_coef[i] = m_coef[i];
      sh_off = m_off;
      sh_ent = m_ent;
    end
    exp_start_nxt = acc;
  endtask

  task automatic cycle(input logic w, input logic r,
                       input logic [11:0] a, input logic [31:0] d,
                       input logic dn, input logic [15:0] res);
    Write = w; Read = r; Address = a; WriteData = d;
    Done = dn; Result = res;
    model_step(w, r, a, d, dn, res);
    @(posedge Clk);
    #1;
    Write = 0; Read = 0; Done = 0;
    exp_start = exp_start_nxt;
    exp_out = m_outs();
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    cycle(1'b1, 1'b0, a, d, 1'b0, 16'h0);
  endtask

  task automatic rd(input logic [11:0] a);
    cycle(1'b0, 1'b1, a, 32'h0, 1'b0, 16'h0);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 16'h0);
  endtask

  task automatic pulse_done(input logic [15:0] res);
    cycle(1'b0, 1'b0, 12'h0, 32'h0, 1'b1, res);
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    #2;
    chk("reset_start", {31'h0, Start}, 32'h0);
    chk("reset_coef0", {16'h0, Coef[0 +: W]}, 32'h0);
    chk("reset_coef3", {16'h0, Coef[3*W +: W]}, 32'h0);
    chk("reset_off_ent", {Entrada, Offset}, 32'h0);
    chk("reset_rvalid", {31'h0, ReadValid}, 32'h0);
    model_reset();
    @(posedge Clk);
    #1;
    Reset = 1'b0;
  endtask

  // Monitor: compares Start, datapath outputs and read responses
  always @(negedge Clk) begin
    if (!Reset) begin
      checks++;
      if (Start !== exp_start) begin
        errors++;
        $display("FAIL start: got %b want %b", Start, exp_start);
      end
      checks++;
      if ({Entrada, Offset, Coef} !== exp_out) begin
        errors++;
        $display("FAIL outputs: got %h want %h",
                 {Entrada, Offset, Coef}, exp_out);
      end
      if (ReadValid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL readvalid: got unexpected %h want none", ReadData);
        end else begin
          logic [31:0] want;
          want = exp_q.pop_front();
          if (ReadData !== want) begin
            errors++;
            $display("FAIL readdata: got %h want %h", ReadData, want);
          end
        end
      end
    end
  end

  initial begin
    logic [11:0] a;
    logic [31:0] d;
    int r;
    Reset = 1'b1;
    Write = 0; Read = 0; Done = 0;
    Address = '0; WriteData = '0; Result = '0;
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;

    for (int k = 0; k < N + 5; k++) rd(BASE + 12'(4 * k));
    idle();

    wr(12'h800, 32'h1234);
    wr(12'h84C, 32'h5678);
    rd(12'h800);
    rd(12'h84C);
    idle();
    chk("coef0", {16'h0, Coef[0 +: W]}, SHADOW ? 32'h0 : 32'h1234);
    chk("coef19", {16'h0, Coef[19*W +: W]}, SHADOW ? 32'h0 : 32'h5678);

    wr(A_CTRL, 32'h1);
    rd(A_STAT);
    wr(A_CTRL, 32'h1);
    rd(A_STAT);
    wr(A_CTRL, 32'h2);
    pulse_done(16'h00AB);
    rd(A_STAT);
    rd(A_RES);
    idle();

    wr(A_CTRL, 32'h1);
    wr(12'h80C, 32'h7777);
    rd(A_STAT);
    rd(12'h80C);
    idle();
    chk("coef3_busy", {16'h0, Coef[3*W +: W]}, 32'h0);
    pulse_done(16'h0042);
    wr(A_CTRL, 32'h3);
    idle();
    chk("coef3_next", {16'h0, Coef[3*W +: W]}, SHADOW ? 32'h7777 : 32'h0);

    do_reset();
    rd(A_STAT);
    rd(12'h800);
    wr(12'h900, 32'hBEEF);
    wr(12'h802, 32'h9999);
    rd(12'h900);
    rd(12'h800);
    rd(12'h802);
    idle();

    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 9);
      a = BASE + 12'(4 * $urandom_range(0, N + 6));
      if ($urandom_range(0, 9) == 0) a[1:0] = 2'($urandom_range(1, 3));
      if (r == 0) a = A_CTRL;
      d = $urandom;
      if (a == A_CTRL) d = 32'($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) do_reset();
      else cycle(r < 4, r >= 3 && r < 7, a, d,
                 $urandom_range(0, 5) == 0, 16'($urandom));
    end
    idle();
    idle();
    chk("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
